cc_branch_unit: RTL and testbench

- Consumer end of the condition-code path: samples CC_ZERO/CARRY/SIGN/PARITY produced by the ALU and its CC latch.
- Evaluates a 4-bit branch condition and sequences the program-counter redirect and pipeline flush.
- Sits between the instruction decoder, the fullALU CC outputs and the PC register. Handles the CC-write/branch-read hazard with a bypass.

---
 rtl/cc_branch_unit_pkg.sv | 36 +++
 rtl/cc_branch_unit_cond_eval.sv | 39 +++
 rtl/cc_branch_unit.sv | 166 ++++++++++++++++
 tb/tb_cc_branch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_branch_unit_pkg.sv
// Shared encodings for the branch unit: 4-bit branch condition codes and FSM states.
package cc_branch_unit_pkg;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_NEVER  = 4'd1,
        COND_EQ     = 4'd2,   // Z
        COND_NE     = 4'd3,   // !Z
        COND_CS     = 4'd4,   // C
        COND_CC     = 4'd5,   // !C
        COND_MI     = 4'd6,   // S
        COND_PL     = 4'd7,   // !S
        COND_PE     = 4'd8,   // P
        COND_PO     = 4'd9,   // !P
        COND_LS     = 4'd10,  // C|Z
        COND_HI     = 4'd11,  // !C&!Z
        COND_LE     = 4'd12,  // S|Z
        COND_GT     = 4'd13,  // !S&!Z
        COND_RSV14  = 4'd14,
        COND_RSV15  = 4'd15
    } cond_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVAL     = 3'd1,
        ST_DECIDE   = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_WAITF    = 3'd4
    } br_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_P = 3;

endpackage

// File: rtl/cc_branch_unit_cond_eval.sv
// Combinational condition evaluator: flags {P,S,C,Z} and a 4-bit condition give taken/illegal.
// Also used by the decoder for skip instructions.
module cc_cond_eval
    import cc_branch_unit_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_condx,
    output logic       o_taken,
    output logic       o_illegal
);
    logic w_z, w_c, w_s, w_p;

    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_s = i_flags[FLAG_S];
    assign w_p = i_flags[FLAG_P];

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_condx)
            COND_ALWAYS: o_taken = 1'b1;
            COND_NEVER:  o_taken = 1'b0;
            COND_EQ:     o_taken = w_z;
            COND_NE:     o_taken = ~w_z;
            COND_CS:     o_taken = w_c;
            COND_CC:     o_taken = ~w_c;
            COND_MI:     o_taken = w_s;
            COND_PL:     o_taken = ~w_s;
            COND_PE:     o_taken = w_p;
            COND_PO:     o_taken = ~w_p;
            COND_LS:     o_taken = w_c | w_z;
            COND_HI:     o_taken = ~w_c & ~w_z;
            COND_LE:     o_taken = w_s | w_z;
            COND_GT:     o_taken = ~w_s & ~w_z;
            default:     o_illegal = 1'b1;  // reserved codes never branch
        endcase
    end
endmodule

// File: rtl/cc_branch_unit.sv
// Branch unit: evaluates condition codes (with CC-latch bypass) and sequences PC redirect + flush.
// Optional macro BR_LINK_EN adds i_br_call / o_link for call-with-link.
module cc_branch_unit
    import cc_branch_unit_pkg::*;
#(
    parameter int OFFSET_W   = 9,
    parameter int WAIT_FETCH = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_fetch,
    input  logic                i_br_req,
    input  logic [3:0]          i_br_condx,
    input  logic                i_br_rel,
    input  logic [OFFSET_W-1:0] i_br_offset,
    input  logic [15:0]         i_br_target,
    input  logic [15:0]         i_pc,
    input  logic                i_cancel,
`ifdef BR_LINK_EN
    input  logic                i_br_call,
    output logic [15:0]         o_link,
`endif
    input  logic                i_cc_zero,
    input  logic                i_cc_carry,
    input  logic                i_cc_sign,
    input  logic                i_cc_parity,
    input  logic                i_ccl_ld,
    input  logic [3:0]          i_cc_next,
    output logic                o_br_ack,
    output logic                o_br_busy,
    output logic                o_br_taken,
    output logic                o_pc_ld,
    output logic [15:0]         o_pc_next,
    output logic                o_flush,
    output logic                o_br_illegal
);
    br_state_e           r_state;
    logic [3:0]          r_condx;
    logic                r_rel;
    logic [OFFSET_W-1:0] r_offset;
    logic [15:0]         r_target;
    logic [15:0]         r_pc;
    logic                r_taken;
    logic                r_illegal;
    logic                r_pc_ld;
    logic                r_flush;
    logic [15:0]         r_pc_next;

    logic [3:0]  w_flags;
    logic        w_taken;
    logic        w_illegal;
    logic        w_accept;
    logic [15:0] w_sext;
    logic [15:0] w_target;

    // A flag write landing in the EVAL cycle must be seen by this branch.
    assign w_flags  = i_ccl_ld ? i_cc_next : {i_cc_parity, i_cc_sign, i_cc_carry, i_cc_zero};
    assign w_accept = (r_state == ST_IDLE) && i_br_req && !i_cancel;
    assign w_sext   = {{(16-OFFSET_W){r_offset[OFFSET_W-1]}}, r_offset};
    assign w_target = r_rel ? (r_pc + w_sext) : r_target;

    cc_cond_eval u_cond_eval (
        .i_flags   (w_flags),
        .i_condx   (r_condx),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

`ifdef BR_LINK_EN
    logic        r_call;
    logic [15:0] r_link;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_call <= 1'b0;
            r_link <= 16'h0000;
        end else begin
            if (w_accept)
                r_call <= i_br_call;
            if (r_state == ST_REDIRECT && r_call)
                r_link <= r_pc + 16'h0001;
        end
    end

    assign o_link = r_link;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_condx   <= 4'h0;
            r_rel     <= 1'b0;
            r_offset  <= '0;
            r_target  <= 16'h0000;
            r_pc      <= 16'h0000;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_pc_ld   <= 1'b0;
            r_flush   <= 1'b0;
            r_pc_next <= 16'h0000;
        end else begin
            r_pc_ld   <= 1'b0;
            r_flush   <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_condx  <= i_br_condx;
                        r_rel    <= i_br_rel;
                        r_offset <= i_br_offset;
                        r_target <= i_br_target;
                        r_pc     <= i_pc;
                        r_state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (i_cancel) begin
                        r_taken <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_taken   <= w_taken;
                        r_illegal <= w_illegal;
                        r_state   <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (i_cancel || !r_taken) begin
                        r_taken <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pc_ld   <= 1'b1;
                        r_flush   <= 1'b1;
                        r_pc_next <= w_target;
                        r_state   <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (WAIT_FETCH != 0) begin
                        r_state <= ST_WAITF;
                    end else begin
                        r_taken <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAITF: begin
                    if (i_fetch) begin
                        r_taken <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_taken <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_br_ack     = w_accept;
    assign o_br_busy    = (r_state != ST_IDLE);
    assign o_br_taken   = r_taken;
    assign o_pc_ld      = r_pc_ld;
    assign o_flush      = r_flush;
    assign o_pc_next    = r_pc_next;
    assign o_br_illegal = r_illegal;
endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed testbench for cc_branch_unit; checks hand-computed values and prints one summary line.
module tb_cc_branch_unit;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_fetch;
    logic        i_br_req;
    logic [3:0]  i_br_condx;
    logic        i_br_rel;
    logic [8:0]  i_br_offset;
    logic [15:0] i_br_target;
    logic [15:0] i_pc;
    logic        i_cancel;
    logic        i_cc_zero, i_cc_carry, i_cc_sign, i_cc_parity;
    logic        i_ccl_ld;
    logic [3:0]  i_cc_next;
    logic        o_br_ack, o_br_busy, o_br_taken, o_pc_ld, o_flush, o_br_illegal;
    logic [15:0] o_pc_next;
`ifdef BR_LINK_EN
    logic        i_br_call;
    logic [15:0] o_link;
`endif

    int checks   = 0;
    int failures = 0;

    cc_branch_unit #(.OFFSET_W(9), .WAIT_FETCH(1)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_fetch      (i_fetch),
        .i_br_req     (i_br_req),
        .i_br_condx   (i_br_condx),
        .i_br_rel     (i_br_rel),
        .i_br_offset  (i_br_offset),
        .i_br_target  (i_br_target),
        .i_pc         (i_pc),
        .i_cancel     (i_cancel),
`ifdef BR_LINK_EN
        .i_br_call    (i_br_call),
        .o_link       (o_link),
`endif
        .i_cc_zero    (i_cc_zero),
        .i_cc_carry   (i_cc_carry),
        .i_cc_sign    (i_cc_sign),
        .i_cc_parity  (i_cc_parity),
        .i_ccl_ld     (i_ccl_ld),
        .i_cc_next    (i_cc_next),
        .o_br_ack     (o_br_ack),
        .o_br_busy    (o_br_busy),
        .o_br_taken   (o_br_taken),
        .o_pc_ld      (o_pc_ld),
        .o_pc_next    (o_pc_next),
        .o_flush      (o_flush),
        .o_br_illegal (o_br_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic request(input logic [3:0] condx, input logic rel, input logic [8:0] off,
                           input logic [15:0] tgt, input logic [15:0] pc, input string tag);
        i_br_req    = 1'b1;
        i_br_condx  = condx;
        i_br_rel    = rel;
        i_br_offset = off;
        i_br_target = tgt;
        i_pc        = pc;
        #1;
        check_eq({tag, "_ack"}, {31'd0, o_br_ack}, 32'd1);
        $display("TXN %s cond=%0d rel=%0d off=%h tgt=%h pc=%h", tag, condx, rel, off, tgt, pc);
        tick();
        i_br_req = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0; i_fetch = 1'b0; i_br_req = 1'b0; i_br_condx = 4'h0;
        i_br_rel = 1'b0; i_br_offset = 9'h000; i_br_target = 16'h0000; i_pc = 16'h0000;
        i_cancel = 1'b0; i_cc_zero = 1'b0; i_cc_carry = 1'b0; i_cc_sign = 1'b0;
        i_cc_parity = 1'b0; i_ccl_ld = 1'b0; i_cc_next = 4'h0;
`ifdef BR_LINK_EN
        i_br_call = 1'b0;
`endif
        #12;
        check_eq("rst_busy",  {31'd0, o_br_busy},  32'd0);
        check_eq("rst_pc_ld", {31'd0, o_pc_ld},    32'd0);
        check_eq("rst_pcnx",  {16'd0, o_pc_next},  32'h0);
        check_eq("rst_taken", {31'd0, o_br_taken}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Relative wrap: FFFE + 4 -> 0002, PC_LD 3 cycles after accept.
        request(4'd0, 1'b1, 9'h004, 16'h0000, 16'hFFFE, "wrap");
        check_eq("wrap_eval_busy", {31'd0, o_br_busy}, 32'd1);
        check_eq("wrap_eval_ack",  {31'd0, o_br_ack},  32'd0);
        tick();
        check_eq("wrap_dec_taken", {31'd0, o_br_taken}, 32'd1);
        check_eq("wrap_dec_pcld",  {31'd0, o_pc_ld},    32'd0);
        tick();
        check_eq("wrap_pcld",  {31'd0, o_pc_ld},  32'd1);
        check_eq("wrap_flush", {31'd0, o_flush},  32'd1);
        check_eq("wrap_pcnx",  {16'd0, o_pc_next}, 32'h0002);
        tick();
        check_eq("wrap_wf_pcld",  {31'd0, o_pc_ld},   32'd0);
        check_eq("wrap_wf_busy",  {31'd0, o_br_busy}, 32'd1);
        tick();
        check_eq("wrap_wf_hold",  {31'd0, o_br_busy}, 32'd1);
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        check_eq("wrap_idle_busy",  {31'd0, o_br_busy},  32'd0);
        check_eq("wrap_idle_taken", {31'd0, o_br_taken}, 32'd0);

        // Bypass: latched Z=0 but CC_NEXT Z=1 in the EVAL cycle.
        i_cc_zero = 1'b0;
        request(4'd2, 1'b0, 9'h000, 16'h1234, 16'h0040, "bypass");
        i_ccl_ld = 1'b1; i_cc_next = 4'b0001;
        tick();
        i_ccl_ld = 1'b0; i_cc_next = 4'b0000;
        check_eq("byp_taken", {31'd0, o_br_taken}, 32'd1);
        tick();
        check_eq("byp_pcld", {31'd0, o_pc_ld},   32'd1);
        check_eq("byp_pcnx", {16'd0, o_pc_next}, 32'h1234);
        i_fetch = 1'b1;
        tick();
        check_eq("byp_wf_busy", {31'd0, o_br_busy}, 32'd1);
        tick();
        i_fetch = 1'b0;
        check_eq("byp_idle", {31'd0, o_br_busy}, 32'd0);

        // Not taken, negative offset; a second request while busy is ignored.
        i_cc_carry = 1'b1;
        request(4'd5, 1'b1, 9'h1F0, 16'h0000, 16'h0100, "nt");
        i_br_req = 1'b1;
        #1;
        check_eq("nt_busy_ack0", {31'd0, o_br_ack}, 32'd0);
        tick();
        check_eq("nt_busy_ack1", {31'd0, o_br_ack},   32'd0);
        check_eq("nt_taken",     {31'd0, o_br_taken}, 32'd0);
        i_br_req = 1'b0;
        tick();
        check_eq("nt_idle",  {31'd0, o_br_busy}, 32'd0);
        check_eq("nt_pcld",  {31'd0, o_pc_ld},   32'd0);
        check_eq("nt_pcnx_hold", {16'd0, o_pc_next}, 32'h1234);
        i_cc_carry = 1'b0;

        // Cancel during EVAL.
        request(4'd0, 1'b0, 9'h000, 16'h5555, 16'h0010, "cancel");
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        check_eq("can_idle",  {31'd0, o_br_busy},  32'd0);
        check_eq("can_taken", {31'd0, o_br_taken}, 32'd0);
        tick();
        check_eq("can_pcld",  {31'd0, o_pc_ld},    32'd0);

        // Cancel together with a request in IDLE: not accepted.
        i_cancel = 1'b1; i_br_req = 1'b1;
        #1;
        check_eq("canreq_ack", {31'd0, o_br_ack}, 32'd0);
        tick();
        i_cancel = 1'b0; i_br_req = 1'b0;
        check_eq("canreq_busy", {31'd0, o_br_busy}, 32'd0);

        // Reserved condition 15: illegal pulse in DECIDE, no redirect.
        request(4'hF, 1'b0, 9'h000, 16'h7777, 16'h0020, "rsv");
        tick();
        check_eq("rsv_illegal", {31'd0, o_br_illegal}, 32'd1);
        check_eq("rsv_taken",   {31'd0, o_br_taken},   32'd0);
        tick();
        check_eq("rsv_ill_off", {31'd0, o_br_illegal}, 32'd0);
        check_eq("rsv_pcld",    {31'd0, o_pc_ld},      32'd0);
        check_eq("rsv_idle",    {31'd0, o_br_busy},    32'd0);

        // Asynchronous reset in the middle of REDIRECT.
        request(4'd0, 1'b0, 9'h000, 16'hABCD, 16'h0030, "rstmid");
        tick();
        tick();
        check_eq("rstmid_pcld", {31'd0, o_pc_ld}, 32'd1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_eq("rstmid_pcld0",  {31'd0, o_pc_ld},    32'd0);
        check_eq("rstmid_flush0", {31'd0, o_flush},    32'd0);
        check_eq("rstmid_taken0", {31'd0, o_br_taken}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check_eq("rstmid_idle", {31'd0, o_br_busy}, 32'd0);

`ifdef BR_LINK_EN
        // Taken call: LINK = PC + 1 the cycle after REDIRECT; WAITF held until FETCH.
        i_br_call = 1'b1;
        request(4'd0, 1'b0, 9'h000, 16'h0200, 16'h00FF, "call");
        i_br_call = 1'b0;
        tick();
        tick();
        check_eq("call_pcld", {31'd0, o_pc_ld}, 32'd1);
        check_eq("call_link_pre", {16'd0, o_link}, 32'h0000);
        tick();
        check_eq("call_link", {16'd0, o_link}, 32'h0100);
        tick();
        check_eq("call_wf_hold", {31'd0, o_br_busy}, 32'd1);
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        check_eq("call_idle", {31'd0, o_br_busy}, 32'd0);
        // Not-taken call leaves LINK unchanged.
        i_br_call = 1'b1;
        request(4'd1, 1'b0, 9'h000, 16'h0300, 16'h0500, "callnt");
        i_br_call = 1'b0;
        tick();
        tick();
        tick();
        check_eq("callnt_link", {16'd0, o_link}, 32'h0100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
